dmem_dump_master: RTL

Synthesizable data-bus initiator for the risc16ba memory system: on command it reads a word range of data memory over the same bus the CPU data port drives (daddr/ddin/doe/dwe0/dwe1) and streams the contents out as big-endian bytes on a valid/ready byte stream. It sits beside the CPU behind a simple request/grant arbiter. Its main use is to dump the image region (default 0xc000–0xffff) to a UART transmitter.

---
 rtl/risc16ba_pkg.sv | 22 ++
 rtl/dmem_dump_master.sv | 114 +++++++++++
 2 files changed

// File: rtl/risc16ba_pkg.sv
// Shared risc16ba definitions: dump master state encoding and data-bus address map.
package risc16ba_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_DONE
  } dump_state_t;

  localparam logic [15:0] LED0_ADDR  = 16'h0200;
  localparam logic [15:0] LED2_ADDR  = 16'h0202;
  localparam logic [15:0] IMAGE_BASE = 16'hc000;
  localparam logic [15:0] IMAGE_LAST = 16'hffff;

  // Integration defaults for a wrapper that ties start_addr/end_addr off.
  localparam logic [15:0] DEFAULT_START = IMAGE_BASE;
  localparam logic [15:0] DEFAULT_END   = IMAGE_LAST;

endpackage

// File: rtl/dmem_dump_master.sv
// Data-bus initiator: reads a word range of data memory and streams it as big-endian bytes.
// 4 cycles per word when grant/ready are high; grant and stream stalls add one cycle each.
module dmem_dump_master
  import risc16ba_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  output logic        busy,
  output logic        done,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] daddr,
  input  logic [15:0] ddin,
  output logic        doe,
  output logic        dwe0,
  output logic        dwe1,
  output logic [15:0] ddout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  dump_state_t state, state_nxt;
  logic [15:0] addr;
  logic [15:0] last;
  logic [15:0] word;
  logic        at_last;

  assign at_last = (addr == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= 16'h0000;
      last <= 16'h0000;
      word <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr <= start_addr & 16'hfffe;
            last <= end_addr & 16'hfffe;
          end
        end
        ST_READ: word <= ddin;
        ST_SEND_LO: begin
          // Modular increment lets a range with last < start wrap through 0x0000.
          if (tx_ready && !at_last) begin
            addr <= addr + 16'd2;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode from registered state only; the bus is dropped while streaming.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    bus_req   = 1'b0;
    doe       = 1'b0;
    daddr     = 16'h0000;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_nxt = ST_READ;
      end
      ST_READ: begin
        bus_req   = 1'b1;
        doe       = 1'b1;
        daddr     = addr;
        state_nxt = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = word[15:8];
        if (tx_ready) state_nxt = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = word[7:0];
        if (tx_ready) state_nxt = at_last ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dwe0  = 1'b0;
  assign dwe1  = 1'b0;
  assign ddout = 16'h0000;

endmodule
